// File: rtl/accumulator_fixed_point_16_bit_if.sv
// accumulator_fixed_point_16_bit_if: start/valid handshake and data bus of the fixed-point accumulator
interface accumulator_fixed_point_16_bit_if #(parameter int N = 16);
    logic         start;
    logic [N-1:0] bias;
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         in_overflow;
    logic         busy;
    logic         out_valid;
    logic [N-1:0] out_data;
    logic         out_overflow;
    modport master (output start, bias, in_valid, in_data, in_overflow,
                    input  busy, out_valid, out_data, out_overflow);
    modport slave  (input  start, bias, in_valid, in_data, in_overflow,
                    output busy, out_valid, out_data, out_overflow);
endinterface

// File: rtl/accumulator_fixed_point_16_bit.sv
// accumulator_fixed_point_16_bit: sums LEN sign-magnitude Q4.12 products onto a bias, saturated result.
// Define ACCUMULATOR_RELU_EN to clamp negative results to zero after saturation.
module accumulator_fixed_point_16_bit #(
    parameter int N     = 16,
    parameter int Q     = 12,
    parameter int LEN   = 8,
    parameter int GUARD = 4
) (
    input logic clk,
    input logic rst,
    accumulator_fixed_point_16_bit_if.slave bus
);
    localparam int A  = N + GUARD;
    localparam int CW = $clog2(LEN + 1);
    localparam logic [A-1:0] MAX = A'((1 << (N - 1)) - 1);
    if (GUARD < $clog2(LEN + 1) || Q >= N || LEN < 1) begin : g_cfg_err
        $error("accumulator_fixed_point_16_bit: invalid parameter set");
    end
    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;
    state_t        state_q, state_d;
    logic [A-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sticky_q, sticky_d;
    logic [N-1:0]  res_q, res_d, hold_q, hold_d;
    logic          res_ovf_q, res_ovf_d, hold_ovf_q, hold_ovf_d;
    logic [A-1:0]  sum, mag;
    logic          neg, sat;
    logic [N-1:0]  word;
    function automatic logic [A-1:0] to_tc(input logic [N-1:0] x);
        logic [A-1:0] m;
        m = {{(GUARD + 1){1'b0}}, x[N-2:0]};
        return x[N-1] ? -m : m;
    endfunction
    // Final sum is formed on the last accepted term so the result is registered on entry to FINISH
    always_comb begin
        sum = acc_q + to_tc(bus.in_data);
        neg = sum[A-1];
        mag = neg ? -sum : sum;
        sat = mag > MAX;
`ifdef ACCUMULATOR_RELU_EN
        word = neg ? '0 : {1'b0, sat ? MAX[N-2:0] : mag[N-2:0]};
`else
        word = {neg, sat ? MAX[N-2:0] : mag[N-2:0]};
`endif
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sticky_d   = sticky_q;
        res_d      = res_q;
        res_ovf_d  = res_ovf_q;
        hold_d     = hold_q;
        hold_ovf_d = hold_ovf_q;
        if (bus.start) begin
            state_d  = ACCUM;
            acc_d    = to_tc(bus.bias);
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (state_q == ACCUM && bus.in_valid) begin
            acc_d    = sum;
            sticky_d = sticky_q | bus.in_overflow;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(LEN - 1)) begin
                state_d   = FINISH;
                res_d     = word;
                res_ovf_d = sticky_d | sat;
            end
        end else if (state_q == FINISH) begin
            state_d    = IDLE;
            hold_d     = res_q;
            hold_ovf_d = res_ovf_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            sticky_q   <= 1'b0;
            res_q      <= '0;
            res_ovf_q  <= 1'b0;
            hold_q     <= '0;
            hold_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sticky_q   <= sticky_d;
            res_q      <= res_d;
            res_ovf_q  <= res_ovf_d;
            hold_q     <= hold_d;
            hold_ovf_q <= hold_ovf_d;
        end
    end
    // A start landing on FINISH cancels delivery; the previously delivered result stays visible
    assign bus.busy         = state_q != IDLE;
    assign bus.out_valid    = state_q == FINISH && !bus.start;
    assign bus.out_data     = bus.out_valid ? res_q : hold_q;
    assign bus.out_overflow = bus.out_valid ? res_ovf_q : hold_ovf_q;
endmodule

// File: tb/tb_accumulator_fixed_point_16_bit.sv
// tb_accumulator_fixed_point_16_bit: table-driven and directed checks of the LEN=4 accumulator
module tb_accumulator_fixed_point_16_bit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    accumulator_fixed_point_16_bit_if #(.N(16)) bus ();
    accumulator_fixed_point_16_bit #(.N(16), .Q(12), .LEN(4), .GUARD(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    typedef struct {
        logic [15:0]      bias;
        logic [3:0][15:0] t;
        logic [3:0]       ov;
        logic [15:0]      ed;
        logic             eo;
    } vec_t;
    vec_t vecs[$];
    int cyc = 0, nv = 0, vcyc = 0, total = 0, passed = 0;
    logic [15:0] v_data;
    logic        v_ovf;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.out_valid) begin
        nv++;
        vcyc   = cyc;
        v_data = bus.out_data;
        v_ovf  = bus.out_overflow;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] relu(input logic [15:0] d);
`ifdef ACCUMULATOR_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction
    task automatic add(input logic [15:0] b, input logic [15:0] t0, input logic [15:0] t1,
                       input logic [15:0] t2, input logic [15:0] t3, input logic [3:0] ov,
                       input logic [15:0] ed, input logic eo);
        vec_t v;
        v.bias = b;
        v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
        v.ov = ov;
        v.ed = relu(ed);
        v.eo = eo;
        vecs.push_back(v);
    endtask
    task automatic wait_valid(input int nv0, input string name);
        for (int k = 0; k < 12 && nv == nv0; k++) tick;
        chk({name, " valid_count"}, nv - nv0, 1);
    endtask
    task automatic run_vec(input vec_t v, input string name);
        int nv0, last;
        nv0 = nv;
        bus.start = 1'b1; bus.bias = v.bias;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = v.t[i]; bus.in_overflow = v.ov[i];
            last = cyc;
            tick;
        end
        bus.in_valid = 1'b0; bus.in_overflow = 1'b0;
        wait_valid(nv0, name);
        chk({name, " data"}, v_data, v.ed);
        chk({name, " ovf"}, v_ovf, v.eo);
        chk({name, " latency"}, vcyc - last, 1);
        chk({name, " busy_after"}, bus.busy, 0);
    endtask
    initial begin
        int nv0;
        bus.start = 0; bus.bias = 0; bus.in_valid = 0; bus.in_data = 0; bus.in_overflow = 0;
        add(16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'b0000, 16'h4000, 0);
        add(16'h0800, 16'h1000, 16'h9800, 16'h0400, 16'h8000, 4'b0000, 16'h0400, 0);
        add(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'b0000, 16'h7FFF, 1);
        add(16'hF000, 16'hF000, 16'hF000, 16'hF000, 16'hF000, 4'b0000, 16'hFFFF, 1);
        add(16'h0000, 16'h7000, 16'h7000, 16'hF000, 16'hF000, 4'b0000, 16'h0000, 0);
        add(16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 4'b0010, 16'h0400, 1);
        add(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 0);
        add(16'h0001, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 0);
        add(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 0);
        add(16'hFFFF, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'hFFFF, 1);
        add(16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h7FFF, 1);
        add(16'h7FFF, 16'h8001, 16'h0001, 16'h0000, 16'h0000, 4'b0000, 16'h7FFF, 0);
        repeat (3) tick;
        chk("reset busy", bus.busy, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset out_data", bus.out_data, 16'h0000);
        chk("reset out_overflow", bus.out_overflow, 0);
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h1000;
        repeat (6) tick;
        bus.in_valid = 1'b0;
        chk("idle ignores in_valid", nv, 0);
        chk("idle busy", bus.busy, 0);
        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        // restart mid-sum with a dropped term, then gapped terms
        nv0 = nv;
        bus.start = 1'b1; bus.bias = 16'h0000;
        tick;
        bus.start = 1'b0;
        chk("restart busy", bus.busy, 1);
        bus.in_valid = 1'b1; bus.in_data = 16'h1000;
        repeat (2) tick;
        bus.start = 1'b1; bus.bias = 16'h0100;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h0200;
            tick;
            bus.in_valid = 1'b0;
            if (i < 3) begin
                repeat (3) tick;
                chk("gap busy", bus.busy, 1);
            end
        end
        wait_valid(nv0, "restart");
        chk("restart data", v_data, 16'h0900);
        chk("restart ovf", v_ovf, 0);
        chk("restart busy_after", bus.busy, 0);
        repeat (3) tick;
        chk("restart single strobe", nv - nv0, 1);
        // start on the FINISH cycle suppresses delivery and keeps 0x0900
        nv0 = nv;
        bus.start = 1'b1; bus.bias = 16'h7000;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h7000;
            tick;
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b1; bus.bias = 16'h0000;
        #2;
        chk("finish-start out_valid", bus.out_valid, 0);
        chk("finish-start out_data", bus.out_data, 16'h0900);
        chk("finish-start out_ovf", bus.out_overflow, 0);
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = 16'h0100;
            tick;
        end
        bus.in_valid = 1'b0;
        wait_valid(nv0, "finish-start");
        chk("finish-start data", v_data, 16'h0400);
        chk("finish-start ovf", v_ovf, 0);
        // reset in the middle of a sum
        bus.start = 1'b1; bus.bias = 16'h0000;
        tick;
        bus.start = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 16'h1000;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0; bus.in_valid = 1'b0;
        chk("midrst busy", bus.busy, 0);
        chk("midrst out_valid", bus.out_valid, 0);
        chk("midrst out_data", bus.out_data, 16'h0000);
        chk("midrst out_ovf", bus.out_overflow, 0);
        run_vec(vecs[0], "post-reset");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
